// File: rtl/core_mem_pkg.sv
// Shared definitions for the data-memory path: access size encodings, controller FSM states
// and the alignment rule applied to every request.
package core_mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10,
        MEM_X = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RESP
    } mem_state_e;

    localparam int unsigned CNT_W = 8;

    // True for requests that must be rejected without touching the SRAM.
    function automatic logic misaligned(input mem_size_e size, input logic [1:0] a);
        case (size)
            MEM_B:   misaligned = 1'b0;
            MEM_H:   misaligned = a[0];
            MEM_W:   misaligned = (a != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Request/response channel between the core MEM stage (master) and the SRAM controller (slave).
interface sram_mem_ctrl_if;
    import core_mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram_mem_ctrl_lane_align.sv
// Combinational lane steering: store data replication plus byte enables, and load word
// shift plus sign/zero extension.
module sram_lane_align
    import core_mem_pkg::*;
(
    input  mem_size_e   st_size_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] st_data_o,
    output logic [3:0]  st_be_n_o,
    input  mem_size_e   ld_size_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift;

    always_comb begin
        st_data_o = st_wdata_i;
        st_be_n_o = 4'b0000;
        case (st_size_i)
            MEM_B: begin
                st_data_o = {4{st_wdata_i[7:0]}};
                st_be_n_o = ~(4'b0001 << st_addr_lo_i);
            end
            MEM_H: begin
                st_data_o = {2{st_wdata_i[15:0]}};
                st_be_n_o = st_addr_lo_i[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                st_data_o = st_wdata_i;
                st_be_n_o = 4'b0000;
            end
        endcase
    end

    assign ld_shift = ld_word_i >> {ld_addr_lo_i, 3'b000};

    always_comb begin
        ld_data_o = ld_word_i;
        case (ld_size_i)
            MEM_B:   ld_data_o = {{24{~ld_unsigned_i & ld_shift[7]}}, ld_shift[7:0]};
            MEM_H:   ld_data_o = {{16{~ld_unsigned_i & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// Single-outstanding load/store controller driving an asynchronous SRAM with registered strobes,
// lane enables and a tristate data bus; returns one response pulse per accepted request.
module sram_mem_ctrl
    import core_mem_pkg::*;
#(
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    sram_mem_ctrl_if.slave mem,
    output logic         ram_ce_n,
    output logic         ram_we_n,
    output logic         ram_oe_n,
    output logic [3:0]   ram_byte_en_n,
    output logic [31:0]  ram_addr,
    inout  wire  [31:0]  ram_data
);

    mem_state_e        state_q;
    logic              ready_q;
    logic              ce_n_q, we_n_q, oe_n_q;
    logic [3:0]        be_n_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              drv_q;
    logic [CNT_W-1:0]  cnt_q;
    mem_size_e         size_q;
    logic [1:0]        addr_lo_q;
    logic              uns_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    mem_size_e         req_size;
    logic [31:0]       st_data;
    logic [3:0]        st_be_n;
    logic [31:0]       ld_data;

    assign req_size = mem_size_e'(mem.req_size);

    sram_lane_align u_align (
        .st_size_i     (req_size),
        .st_addr_lo_i  (mem.req_addr[1:0]),
        .st_wdata_i    (mem.req_wdata),
        .st_data_o     (st_data),
        .st_be_n_o     (st_be_n),
        .ld_size_i     (size_q),
        .ld_addr_lo_i  (addr_lo_q),
        .ld_unsigned_i (uns_q),
        .ld_word_i     (ram_data),
        .ld_data_o     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            be_n_q      <= 4'hF;
            addr_q      <= '0;
            wdata_q     <= '0;
            drv_q       <= 1'b0;
            cnt_q       <= '0;
            size_q      <= MEM_B;
            addr_lo_q   <= 2'b00;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem.req_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        size_q    <= req_size;
                        addr_lo_q <= mem.req_addr[1:0];
                        uns_q     <= mem.req_unsigned;
                        if (misaligned(req_size, mem.req_addr[1:0])) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (mem.req_we) begin
                            state_q <= ST_WR_SETUP;
                            ce_n_q  <= 1'b0;
                            be_n_q  <= st_be_n;
                            addr_q  <= {mem.req_addr[31:2], 2'b00};
                            wdata_q <= st_data;
                            drv_q   <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            ce_n_q  <= 1'b0;
                            oe_n_q  <= 1'b0;
                            be_n_q  <= 4'b0000;
                            addr_q  <= {mem.req_addr[31:2], 2'b00};
                            cnt_q   <= CNT_W'(RD_WAIT - 1);
                        end
                    end
                end
                ST_RD: begin
                    if (cnt_q == '0) begin
                        // Data is captured on the same edge that releases oe_n/ce_n.
                        state_q     <= ST_RESP;
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        be_n_q      <= 4'hF;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= ld_data;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    state_q <= ST_WR_PULSE;
                    we_n_q  <= 1'b0;
                    cnt_q   <= CNT_W'(WR_WAIT - 1);
                end
                ST_WR_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_WR_HOLD;
                        we_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    state_q     <= ST_RESP;
                    ce_n_q      <= 1'b1;
                    be_n_q      <= 4'hF;
                    drv_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem.req_ready = ready_q;
    assign mem.rsp_valid = rsp_valid_q;
    assign mem.rsp_rdata = rsp_rdata_q;
    assign mem.rsp_err   = rsp_err_q;

    assign ram_ce_n      = ce_n_q;
    assign ram_we_n      = we_n_q;
    assign ram_oe_n      = oe_n_q;
    assign ram_byte_en_n = be_n_q;
    assign ram_addr      = addr_q;
    assign ram_data      = drv_q ? wdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl against a behavioural asynchronous SRAM, with a response
// scoreboard checking data, error flag and latency.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [31:0] ram_data;
    logic        ram_ce_n, ram_we_n, ram_oe_n;
    logic [3:0]  ram_byte_en_n;
    logic [31:0] ram_addr;

    sram_mem_ctrl_if bus();

    sram_mem_ctrl #(.RD_WAIT(1), .WR_WAIT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (bus),
        .ram_ce_n      (ram_ce_n),
        .ram_we_n      (ram_we_n),
        .ram_oe_n      (ram_oe_n),
        .ram_byte_en_n (ram_byte_en_n),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data)
    );

    always #5 clk = ~clk;

    logic [31:0] model [0:255];
    logic        model_rd;

    assign model_rd = !ram_ce_n && !ram_oe_n && ram_we_n;
    assign ram_data = model_rd ? model[ram_addr[9:2]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n) begin
            for (int i = 0; i < 4; i++)
                if (!ram_byte_en_n[i]) model[ram_addr[9:2]][8*i +: 8] <= ram_data[8*i +: 8];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_req(
        input  string       tag,
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] exp_rdata,
        input  logic        exp_err,
        input  int          exp_lat,
        input  logic [31:0] exp_bus,
        output int          we_low,
        output int          drv_cnt,
        output int          ce_cnt,
        output logic [3:0]  be_seen,
        output logic [31:0] bus_seen,
        output logic [31:0] addr_seen
    );
        int   n;
        logic got;
        exp_t e;
        we_low = 0; drv_cnt = 0; ce_cnt = 0;
        be_seen = 4'hF; bus_seen = '0; addr_seen = '0;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check({tag, "_ready_timeout"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = $urandom_range(0, 1);
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = $urandom_range(0, 1);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else begin
                if (!ram_we_n) begin
                    we_low++;
                    be_seen   = ram_byte_en_n;
                    bus_seen  = ram_data;
                    addr_seen = ram_addr;
                end
                if (!ram_oe_n) begin
                    be_seen   = ram_byte_en_n;
                    addr_seen = ram_addr;
                end
                if (ram_data === exp_bus) drv_cnt++;
                if (!ram_ce_n) ce_cnt++;
            end
        end
        if (!got) begin
            check({tag, "_rsp_timeout"}, {31'b0, bus.rsp_valid}, 32'd1);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            check({tag, "_latency"}, n, e.lat);
            check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
            check({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
            @(negedge clk);
            check({tag, "_pulse"}, {31'b0, bus.rsp_valid}, 32'd0);
            check({tag, "_hold"}, bus.rsp_rdata, e.rdata);
        end
    endtask

    initial begin
        int          wl, dc, cc, cnt;
        logic [3:0]  be;
        logic [31:0] bd, ad;

        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ce_n", {31'b0, ram_ce_n}, 32'd1);
        check("rst_we_n", {31'b0, ram_we_n}, 32'd1);
        check("rst_oe_n", {31'b0, ram_oe_n}, 32'd1);
        check("rst_be_n", {28'b0, ram_byte_en_n}, 32'hF);
        check("rst_addr", ram_addr, 32'h0);
        check("rst_drive", {31'b0, dut.drv_q}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        check("rst_err", {31'b0, bus.rsp_err}, 32'd0);
        check("rst_ready", {31'b0, bus.req_ready}, 32'd1);

        // sw: one-cycle write pulse inside three cycles of driven data
        do_req("sw", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 4,
               32'hDEADBEEF, wl, dc, cc, be, bd, ad);
        check("sw_we_low", wl, 1);
        check("sw_drv_cycles", dc, 3);
        check("sw_be_n", {28'b0, be}, 32'h0);
        check("sw_addr", ad, 32'h100);
        check("sw_model", model[8'h40], 32'hDEADBEEF);

        do_req("sb", 1'b1, 2'b00, 1'b0, 32'h103, 32'h123456A5, 32'h0, 1'b0, 4,
               32'hA5A5A5A5, wl, dc, cc, be, bd, ad);
        check("sb_be_n", {28'b0, be}, 32'h7);
        check("sb_bus", bd, 32'hA5A5A5A5);
        check("sb_model", model[8'h40], 32'hA5ADBEEF);

        do_req("lw_back", 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'hA5ADBEEF, 1'b0, 2,
               32'hFFFF_FFFF, wl, dc, cc, be, bd, ad);
        check("lw_back_be_n", {28'b0, be}, 32'h0);

        do_req("sh", 1'b1, 2'b01, 1'b0, 32'h102, 32'h9999CAFE, 32'h0, 1'b0, 4,
               32'hCAFECAFE, wl, dc, cc, be, bd, ad);
        check("sh_be_n", {28'b0, be}, 32'h3);
        check("sh_model", model[8'h40], 32'hCAFEBEEF);

        model[8'h40] = 32'h80123456;
        do_req("lb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2,
               32'hFFFF_FFFF, wl, dc, cc, be, bd, ad);
        do_req("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h00000080, 1'b0, 2,
               32'hFFFF_FFFF, wl, dc, cc, be, bd, ad);

        model[8'h40] = 32'hF00D1234;
        do_req("lh", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFFF00D, 1'b0, 2,
               32'hFFFF_FFFF, wl, dc, cc, be, bd, ad);
        do_req("lhu", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h00001234, 1'b0, 2,
               32'hFFFF_FFFF, wl, dc, cc, be, bd, ad);
        do_req("lh_pos", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h00001234, 1'b0, 2,
               32'hFFFF_FFFF, wl, dc, cc, be, bd, ad);

        do_req("lw_mis", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1,
               32'hFFFF_FFFF, wl, dc, cc, be, bd, ad);
        check("lw_mis_ce_cycles", cc, 0);
        do_req("sz11", 1'b1, 2'b11, 1'b0, 32'h100, 32'h11111111, 32'h0, 1'b1, 1,
               32'hFFFF_FFFF, wl, dc, cc, be, bd, ad);
        check("sz11_ce_cycles", cc, 0);
        check("sz11_model", model[8'h40], 32'hF00D1234);

        // Reset asserted while the write strobe is low
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h180; bus.req_wdata = 32'h5A5A5A5A;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_setup_we_n", {31'b0, ram_we_n}, 32'd1);
        @(negedge clk);
        check("abort_pulse_we_n", {31'b0, ram_we_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ce_n", {31'b0, ram_ce_n}, 32'd1);
        check("abort_we_n", {31'b0, ram_we_n}, 32'd1);
        check("abort_oe_n", {31'b0, ram_oe_n}, 32'd1);
        check("abort_be_n", {28'b0, ram_byte_en_n}, 32'hF);
        check("abort_drive", {31'b0, dut.drv_q}, 32'd0);
        check("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) cnt++;
        end
        check("abort_no_rsp", cnt, 0);
        check("abort_ready", {31'b0, bus.req_ready}, 32'd1);

        model[8'h60] = 32'h0BADF00D;
        do_req("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h180, 32'h0, 32'h0BADF00D, 1'b0, 2,
               32'hFFFF_FFFF, wl, dc, cc, be, bd, ad);
        check("lw_after_rst_addr", ad, 32'h180);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
